bp_hb_fill_arbiter: RTL and testbench
=====================================

# bp_hb_fill_arbiter

Arbitrates the I-cache and D-cache fill/writeback streams of the unicore HammerBlade BlackParrot onto the single 64-bit memory endpoint toward the manycore. Each request is tagged in the return-payload DID field with requester ID and sequence tag. Returns are steered back to the owning cache. Multi-beat writebacks lock the link, and outstanding requests are credit-limited per requester.

## Interface
Parameters:
- paddr_width_p, 42, physical address width
- block_width_p, 128, cache block width
- fill_width_p, 64, link beat width; beats per block = block_width_p/fill_width_p (power of two, ≥1)
- did_width_p, 19, DID width carried with requests and echoed on returns
- max_outstanding_p, 4, per-requester outstanding request limit (power of two, ≥2)

Ports (N ∈ {0 = icache, 1 = dcache}). One clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- reqN_v_i  in  1  request beat valid
- reqN_ready_and_o  out  1  beat accepted when v & ready
- reqN_we_i  in  1  1 = writeback (block beats), 0 = fill read (1 beat)
- reqN_addr_i  in  paddr_width_p  block address, sampled on first beat
- reqN_data_i  in  fill_width_p  write data beat
- mem_v_o  out  1  link beat valid
- mem_ready_and_i  in  1  link accepts beat
- mem_we_o  out  1  write flag
- mem_addr_o  out  paddr_width_p  address of current transaction
- mem_data_o  out  fill_width_p  beat data
- mem_did_o  out  did_width_p  {zeros, tag[lg(max_outstanding_p)-1:0], requester ID}
- mem_last_o  out  1  final beat of transaction
- ret_v_i  in  1  return beat valid (no backpressure)
- ret_did_i  in  did_width_p  echoed DID
- ret_data_i  in  fill_width_p  return data
- ret_last_i  in  1  final return beat
- retN_v_o  out  1  return beat for requester N
- ret_data_o  out  fill_width_p  shared return data
- err_o  out  1  sticky protocol error

## Operation
- States: IDLE, BURST.
- IDLE: a requester is eligible when reqN_v_i = 1 and its outstanding count < max_outstanding_p. Arbitration is round-robin; the pointer resets to 0. The grantee drives mem_*, only it sees ready = mem_ready_and_i, and the other sees ready = 0.
- Read handshake: mem_last_o = 1, count +1, tag +1 (modulo), pointer moves to the other requester, and the arbiter stays in IDLE.
- Write first-beat handshake with beats > 1: lock the grantee, capture the address, beat counter = 1, go to BURST.
- BURST: only the locked requester is passed and eligibility is ignored. mem_last_o is asserted when beat counter = beats-1. The last-beat handshake increments count and tag, moves the pointer to the other requester, and returns to IDLE.
- Returns: retN_v_o = ret_v_i & (ret_did_i[0] == N), and ret_data_o = ret_data_i. ret_v_i & ret_last_i decrements count[ret_did_i[0]].
- Increment and decrement of the same count in the same cycle leaves it unchanged.
- A decrement when count = 0 sets err_o and leaves count at 0. err_o clears only on reset.
- Reset, asynchronous and at any point including mid-BURST: state IDLE, counts 0, tags 0, pointer 0, err_o 0, all v/ready outputs 0. A partial burst is abandoned; the requester must restart it.

## Timing
- Request path is combinational: 0-cycle latency from reqN to mem_*. Ready is never registered.
- Return path is combinational: 0-cycle latency.
- Eligibility uses the registered count, so a slot freed by a return is usable the next cycle.
- mem_v_o may drop without a handshake only in IDLE when the requester withdraws. In BURST, the requester must hold v until the last beat.

## Configuration
- BP_HB_FILL_ARB_DCACHE_PRIO_EN defined: fixed priority, requester 1 (dcache) wins whenever eligible. The pointer register is removed.
- Not defined: round-robin as above.
- BURST locking, credits and return routing are identical in both modes.

## Test plan
- Both requesters issue reads at reset, with ready always 1: grants alternate 0,1,0,1. mem_did_o = 0x0, 0x1, 0x2, 0x3 (tag<<1 | ID).
- Requester 1 writeback (2 beats) while requester 0 asserts a read: the two beats are consecutive with mem_last_o on beat 2, and requester 0 is granted the cycle after.
- Requester 0 issues 4 reads with no returns: the 5th is blocked (ready 0). A return with DID 0x0 and last allows the 5th to be accepted the next cycle.
- ret_v_i = 1 with DID 0x3 and last = 1, while requester 1 issues a read the same cycle: ret1_v_o = 1, and count1 is unchanged.
- Return with last for requester 0 when count0 = 0: err_o = 1 and stays 1. Reset asserted mid-BURST clears err_o, and all outputs return to 0.
- With the macro defined and both requesters continuously reading: requester 1 receives every grant until its count reaches 4, then requester 0 is granted.

Source files
------------

// File: rtl/bp_hb_fill_arbiter.sv
// Fill/writeback arbiter: I$ (0) and D$ (1) share one 64-bit link; DID = {tag, id}, credit-limited per requester.
// Define BP_HB_FILL_ARB_DCACHE_PRIO_EN for fixed D$ priority instead of round-robin.
module bp_hb_fill_arbiter #(
  parameter int paddr_width_p     = 42,
  parameter int block_width_p     = 128,
  parameter int fill_width_p      = 64,
  parameter int did_width_p       = 19,
  parameter int max_outstanding_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req0_v_i,
  output logic                     req0_ready_and_o,
  input  logic                     req0_we_i,
  input  logic [paddr_width_p-1:0] req0_addr_i,
  input  logic [fill_width_p-1:0]  req0_data_i,
  input  logic                     req1_v_i,
  output logic                     req1_ready_and_o,
  input  logic                     req1_we_i,
  input  logic [paddr_width_p-1:0] req1_addr_i,
  input  logic [fill_width_p-1:0]  req1_data_i,
  output logic                     mem_v_o,
  input  logic                     mem_ready_and_i,
  output logic                     mem_we_o,
  output logic [paddr_width_p-1:0] mem_addr_o,
  output logic [fill_width_p-1:0]  mem_data_o,
  output logic [did_width_p-1:0]   mem_did_o,
  output logic                     mem_last_o,
  input  logic                     ret_v_i,
  input  logic [did_width_p-1:0]   ret_did_i,
  input  logic [fill_width_p-1:0]  ret_data_i,
  input  logic                     ret_last_i,
  output logic                     ret0_v_o,
  output logic                     ret1_v_o,
  output logic [fill_width_p-1:0]  ret_data_o,
  output logic                     err_o
);
  localparam int beats_lp    = block_width_p / fill_width_p;
  localparam int lg_beats_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int lg_mo_lp    = $clog2(max_outstanding_p);
  localparam int cnt_w_lp    = lg_mo_lp + 1;

  typedef enum logic {e_idle, e_burst} state_e;

  state_e                          state_r, state_n;
  logic [1:0][cnt_w_lp-1:0]        cnt_r;
  logic [1:0][lg_mo_lp-1:0]        tag_r;
  logic                            lock_r;
  logic [lg_beats_lp-1:0]          beat_r;
  logic [paddr_width_p-1:0]        addr_r;
  logic                            err_r;
`ifndef BP_HB_FILL_ARB_DCACHE_PRIO_EN
  logic                            ptr_r;
`endif

  logic [1:0]                      req_v, req_we, elig, inc, dec;
  logic [1:0][paddr_width_p-1:0]   req_addr;
  logic [1:0][fill_width_p-1:0]    req_data;
  logic                            gnt, gnt_act, burst, hs, done, start;

  assign req_v    = {req1_v_i, req0_v_i};
  assign req_we   = {req1_we_i, req0_we_i};
  assign req_addr = {req1_addr_i, req0_addr_i};
  assign req_data = {req1_data_i, req0_data_i};
  assign burst    = (state_r == e_burst);

  for (genvar i = 0; i < 2; i++) begin : g_elig
    assign elig[i] = req_v[i] & (cnt_r[i] < cnt_w_lp'(max_outstanding_p));
  end

  always_comb begin
    state_n    = state_r;
    gnt        = 1'b0;
    gnt_act    = 1'b0;
    mem_did_o  = '0;
    if (burst) begin
      gnt     = lock_r;
      gnt_act = 1'b1;
    end else begin
      gnt_act = |elig;
`ifdef BP_HB_FILL_ARB_DCACHE_PRIO_EN
      gnt     = elig[1];
`else
      gnt     = ptr_r ? elig[1] : ~elig[0];
`endif
    end
    // Outputs are forced quiet while reset is held, even if requesters keep v high.
    mem_v_o    = ~reset_i & gnt_act & req_v[gnt];
    mem_we_o   = burst | req_we[gnt];
    mem_addr_o = burst ? addr_r : req_addr[gnt];
    mem_data_o = req_data[gnt];
    mem_last_o = burst ? (beat_r == lg_beats_lp'(beats_lp - 1))
                       : (~req_we[gnt] | (beats_lp == 1));
    mem_did_o[lg_mo_lp:0] = {tag_r[gnt], gnt};
    req0_ready_and_o = ~reset_i & mem_ready_and_i & gnt_act & ~gnt;
    req1_ready_and_o = ~reset_i & mem_ready_and_i & gnt_act &  gnt;
    hs    = mem_v_o & mem_ready_and_i;
    done  = hs & mem_last_o;
    start = hs & ~mem_last_o & ~burst;
    if (start)      state_n = e_burst;
    else if (done)  state_n = e_idle;
  end

  assign inc = {2{done}} & {gnt, ~gnt};
  assign dec = {2{ret_v_i & ret_last_i}} & {ret_did_i[0], ~ret_did_i[0]};

  assign ret0_v_o   = ~reset_i & ret_v_i & ~ret_did_i[0];
  assign ret1_v_o   = ~reset_i & ret_v_i &  ret_did_i[0];
  assign ret_data_o = ret_data_i;
  assign err_o      = err_r;

  logic unused_did;
  assign unused_did = ^ret_did_i[did_width_p-1:1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      cnt_r   <= '0;
      tag_r   <= '0;
      lock_r  <= 1'b0;
      beat_r  <= '0;
      addr_r  <= '0;
      err_r   <= 1'b0;
`ifndef BP_HB_FILL_ARB_DCACHE_PRIO_EN
      ptr_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      if (start) begin
        lock_r <= gnt;
        addr_r <= req_addr[gnt];
        beat_r <= lg_beats_lp'(1);
      end else if (burst & hs) begin
        beat_r <= beat_r + 1'b1;
      end
      if (done) begin
        tag_r[gnt] <= tag_r[gnt] + 1'b1;
`ifndef BP_HB_FILL_ARB_DCACHE_PRIO_EN
        ptr_r      <= ~gnt;
`endif
      end
      // Simultaneous issue and retire cancel; underflow is flagged, count pinned at 0.
      for (int i = 0; i < 2; i++) begin
        if (inc[i] & ~dec[i])
          cnt_r[i] <= cnt_r[i] + 1'b1;
        else if (dec[i] & ~inc[i] & (cnt_r[i] != '0))
          cnt_r[i] <= cnt_r[i] - 1'b1;
        if (dec[i] & (cnt_r[i] == '0))
          err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bp_hb_fill_arbiter.sv
// Self-checking bench for bp_hb_fill_arbiter: directed scenarios, then random traffic against a reference model.
module tb_bp_hb_fill_arbiter;
  localparam int PA = 42, FW = 64, DW = 19, MO = 4, BEATS = 2;

  logic          clk = 1'b0, reset_i = 1'b1;
  logic          req0_v_i = 0, req0_we_i = 0, req1_v_i = 0, req1_we_i = 0;
  logic [PA-1:0] req0_addr_i = '0, req1_addr_i = '0;
  logic [FW-1:0] req0_data_i = '0, req1_data_i = '0;
  logic          req0_ready_and_o, req1_ready_and_o;
  logic          mem_v_o, mem_we_o, mem_last_o, mem_ready_and_i = 0;
  logic [PA-1:0] mem_addr_o;
  logic [FW-1:0] mem_data_o, ret_data_o;
  logic [DW-1:0] mem_did_o;
  logic          ret_v_i = 0, ret_last_i = 0;
  logic [DW-1:0] ret_did_i = '0;
  logic [FW-1:0] ret_data_i = '0;
  logic          ret0_v_o, ret1_v_o, err_o;

  bp_hb_fill_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_v_i(req0_v_i), .req0_ready_and_o(req0_ready_and_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req1_v_i(req1_v_i), .req1_ready_and_o(req1_ready_and_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .mem_v_o(mem_v_o), .mem_ready_and_i(mem_ready_and_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_did_o(mem_did_o), .mem_last_o(mem_last_o),
    .ret_v_i(ret_v_i), .ret_did_i(ret_did_i), .ret_data_i(ret_data_i), .ret_last_i(ret_last_i),
    .ret0_v_o(ret0_v_o), .ret1_v_o(ret1_v_o), .ret_data_o(ret_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: outstanding counts, tags, whose turn it is, and an in-flight writeback.
  int            m_cnt[2], m_tag[2], m_turn, m_lock, m_beat;
  bit            m_burst, m_err;
  logic [PA-1:0] m_addr;
  bit            p_hs, p_last, p_start;
  int            p_g;
  logic [PA-1:0] p_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '{0, 0}; m_tag = '{0, 0}; m_turn = 0; m_lock = 0; m_beat = 0;
    m_burst = 0; m_err = 0; m_addr = '0; p_hs = 0; p_last = 0; p_start = 0; p_g = 0;
  endtask

  task automatic model_check();
    bit v[2], we[2], el[2], act, ev, elast;
    logic [PA-1:0] a[2], ea;
    logic [FW-1:0] d[2];
    int g;
    v = '{req0_v_i, req1_v_i}; we = '{req0_we_i, req1_we_i};
    a = '{req0_addr_i, req1_addr_i}; d = '{req0_data_i, req1_data_i};
    p_hs = 0; p_start = 0;
    if (reset_i) begin
      chk("rst_mem_v", mem_v_o, 0); chk("rst_rdy0", req0_ready_and_o, 0);
      chk("rst_rdy1", req1_ready_and_o, 0); chk("rst_ret0", ret0_v_o, 0);
      chk("rst_ret1", ret1_v_o, 0); chk("rst_err", err_o, 0);
      return;
    end
    if (m_burst) begin
      g = m_lock; act = 1; ev = v[g]; elast = (m_beat == BEATS - 1); ea = m_addr;
    end else begin
      el[0] = v[0] && m_cnt[0] < MO; el[1] = v[1] && m_cnt[1] < MO;
      act = el[0] | el[1]; ev = act;
`ifdef BP_HB_FILL_ARB_DCACHE_PRIO_EN
      g = el[1] ? 1 : 0;
`else
      g = el[m_turn] ? m_turn : 1 - m_turn;
`endif
      elast = !we[g] || BEATS == 1; ea = a[g];
    end
    chk("mem_v", mem_v_o, ev);
    if (ev) begin
      chk("mem_did", mem_did_o, (m_tag[g] << 1) | g);
      chk("mem_last", mem_last_o, elast);
      chk("mem_addr", mem_addr_o, ea);
      chk("mem_data", mem_data_o, d[g]);
      chk("mem_we", mem_we_o, m_burst || we[g]);
    end
    chk("rdy0", req0_ready_and_o, act && g == 0 && mem_ready_and_i);
    chk("rdy1", req1_ready_and_o, act && g == 1 && mem_ready_and_i);
    chk("ret0_v", ret0_v_o, ret_v_i && ret_did_i[0] == 1'b0);
    chk("ret1_v", ret1_v_o, ret_v_i && ret_did_i[0] == 1'b1);
    if (ret_v_i) chk("ret_data", ret_data_o, ret_data_i);
    chk("err", err_o, m_err);
    p_hs = ev && mem_ready_and_i; p_g = g; p_last = elast; p_addr = a[g];
    p_start = !m_burst && p_hs && !elast;
  endtask

  task automatic model_update();
    bit inc, dec;
    if (reset_i) begin model_reset(); return; end
    for (int i = 0; i < 2; i++) begin
      inc = p_hs && p_last && p_g == i;
      dec = ret_v_i && ret_last_i && ret_did_i[0] == i[0];
      if (dec && m_cnt[i] == 0) m_err = 1;
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
    end
    if (p_hs && p_last) begin
      m_tag[p_g] = (m_tag[p_g] + 1) % MO; m_turn = 1 - p_g; m_burst = 0;
    end else if (p_start) begin
      m_burst = 1; m_lock = p_g; m_beat = 1; m_addr = p_addr;
    end else if (m_burst && p_hs) m_beat++;
  endtask

  task automatic settle(); @(negedge clk); model_check(); endtask
  task automatic adv();    @(posedge clk); model_update(); #1; endtask
  task automatic tick();   settle(); adv(); endtask

  task automatic ret(input int id, input int n);
    ret_v_i = 1; ret_last_i = 1; ret_did_i = '0; ret_did_i[0] = id[0];
    for (int k = 0; k < n; k++) tick();
    ret_v_i = 0; ret_last_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit act[2], awe[2];
    logic [PA-1:0] aad[2];
    int id;
    model_reset();
    req0_v_i = 1;  // outputs must stay quiet under reset
    tick(); tick();
    req0_v_i = 0; reset_i = 0;

    // Alternating reads from reset
    req0_v_i = 1; req1_v_i = 1; req0_addr_i = 'h100; req1_addr_i = 'h200; mem_ready_and_i = 1;
    for (int k = 0; k < 4; k++) begin
      settle(); chk("rr_did", mem_did_o, k); chk("rr_addr", mem_addr_o, (k % 2) ? 'h200 : 'h100); adv();
    end
    req0_v_i = 0; req1_v_i = 0;
    for (int k = 0; k < 4; k++) ret(k % 2, 1);

    // Writeback burst holds the link; waiting read goes right after
    req0_v_i = 1; tick();
    req1_v_i = 1; req1_we_i = 1; req1_addr_i = 'h340; req1_data_i = 'hAAAA;
    settle(); chk("wb_b1_last", mem_last_o, 0); chk("wb_b1_rdy1", req1_ready_and_o, 1);
    chk("wb_b1_rdy0", req0_ready_and_o, 0); chk("wb_b1_we", mem_we_o, 1); adv();
    req1_data_i = 'hBBBB; req1_addr_i = 'h0;
    settle(); chk("wb_b2_last", mem_last_o, 1); chk("wb_b2_data", mem_data_o, 'hBBBB);
    chk("wb_b2_addr", mem_addr_o, 'h340); adv();
    req1_v_i = 0; req1_we_i = 0;
    settle(); chk("wb_after_rdy0", req0_ready_and_o, 1); chk("wb_after_addr", mem_addr_o, 'h100); adv();
    req0_v_i = 0;
    ret(0, 2); ret(1, 1);

    // Credit limit
    req0_v_i = 1;
    for (int k = 0; k < 4; k++) begin settle(); chk("cr_rdy", req0_ready_and_o, 1); adv(); end
    ret_v_i = 1; ret_last_i = 1; ret_did_i = '0;
    settle(); chk("cr_block_rdy", req0_ready_and_o, 0); chk("cr_block_v", mem_v_o, 0); adv();
    ret_v_i = 0; ret_last_i = 0;
    settle(); chk("cr_freed_rdy", req0_ready_and_o, 1); adv();
    req0_v_i = 0; ret(0, 4);

    // Issue and retire on the same requester in one cycle
    req1_v_i = 1; tick();
    ret_v_i = 1; ret_last_i = 1; ret_did_i = 'h3;
    settle(); chk("same_ret1", ret1_v_o, 1); chk("same_ret0", ret0_v_o, 0); chk("same_rdy1", req1_ready_and_o, 1); adv();
    ret_v_i = 0; ret_last_i = 0;
    for (int k = 0; k < 3; k++) begin settle(); chk("same_fill_rdy", req1_ready_and_o, 1); adv(); end
    settle(); chk("same_full_rdy", req1_ready_and_o, 0); adv();
    req1_v_i = 0; ret(1, 4);

    // Underflow error is sticky until reset, reset abandons a burst
    ret(0, 1);
    settle(); chk("err_set", err_o, 1); adv();
    settle(); chk("err_hold", err_o, 1); adv();
    req1_v_i = 1; req1_we_i = 1; tick();
    #2 reset_i = 1;
    settle(); chk("err_rst", err_o, 0); adv();
    req1_v_i = 0; req1_we_i = 0; tick();
    reset_i = 0;

`ifdef BP_HB_FILL_ARB_DCACHE_PRIO_EN
    req0_v_i = 1; req1_v_i = 1;
    for (int k = 0; k < 4; k++) begin
      settle(); chk("prio_rdy1", req1_ready_and_o, 1); chk("prio_rdy0", req0_ready_and_o, 0); adv();
    end
    settle(); chk("prio_rdy0_after", req0_ready_and_o, 1); adv();
    req0_v_i = 0; req1_v_i = 0;
    ret(1, 4); ret(0, 1);
`endif

    // Random traffic; requesters hold their request until it completes
    act = '{0, 0};
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++)
        if (!act[i] && $urandom_range(0, 2) != 0) begin
          act[i] = 1; awe[i] = ($urandom_range(0, 3) == 0); aad[i] = PA'({$urandom, $urandom});
        end
      req0_v_i = act[0]; req0_we_i = awe[0]; req0_addr_i = aad[0]; req0_data_i = FW'({$urandom, $urandom});
      req1_v_i = act[1]; req1_we_i = awe[1]; req1_addr_i = aad[1]; req1_data_i = FW'({$urandom, $urandom});
      mem_ready_and_i = ($urandom_range(0, 3) != 0);
      id = $urandom_range(0, 1);
      ret_v_i = (m_cnt[id] > 0) && ($urandom_range(0, 1) == 1);
      ret_last_i = ($urandom_range(0, 3) != 0);
      ret_did_i = '0; ret_did_i[0] = id[0]; ret_did_i[2:1] = 2'($urandom_range(0, 3));
      ret_data_i = FW'({$urandom, $urandom});
      tick();
      if (p_hs && p_last) act[p_g] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
